// File: rtl/wb_stage.sv
// Writeback stage: holds the retiring memory-stage instruction and one buffered
// long-latency result, arbitrates both onto the single register-file write port,
// and tracks registers still owed by the long-latency unit for decode stalls.
module wb_stage #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        ms_valid,
    output logic        ms_ready,
    input  logic [31:0] ms_pc,
    input  logic        ms_we,
    input  logic [4:0]  ms_waddr,
    input  logic [31:0] ms_wdata,

    input  logic        ll_valid,
    output logic        ll_ready,
    input  logic [4:0]  ll_waddr,
    input  logic [31:0] ll_wdata,

    input  logic        ll_issue,
    input  logic [4:0]  ll_issue_addr,
    input  logic [4:0]  chk_addr1,
    input  logic [4:0]  chk_addr2,
    output logic        chk_busy1,
    output logic        chk_busy2,

    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,

    output logic [31:0] debug_wb_pc,
    output logic        debug_wb_valid
);

    localparam logic [CNT_W-1:0] StarveMax = CNT_W'(STARVE_LIMIT);

    // WB pipeline register
    logic        ws_valid_q;
    logic [31:0] ws_pc_q;
    logic        ws_we_q;
    logic [4:0]  ws_waddr_q;
    logic [31:0] ws_wdata_q;

    // Long-latency hold buffer
    logic        hold_valid_q;
    logic [4:0]  hold_waddr_q;
    logic [31:0] hold_wdata_q;

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic [31:0]      busy_q, busy_d;

    logic force_ll;
    logic ws_grant;
    logic hold_grant;
    logic ws_retire;
    logic ms_fire;
    logic ll_fire;

    // Arbitration and handshakes
    always_comb begin
        force_ll   = hold_valid_q && (starve_cnt_q == StarveMax);
        ws_grant   = ws_valid_q && ws_we_q && !force_ll;
        hold_grant = hold_valid_q && !ws_grant;
        ws_retire  = ws_valid_q && (!ws_we_q || ws_grant);
        ms_ready   = !ws_valid_q || ws_retire;
        ll_ready   = !hold_valid_q || hold_grant;
        ms_fire    = ms_valid && ms_ready;
        ll_fire    = ll_valid && ll_ready;
    end

    // Register-file write port; r0 writes are granted but suppressed
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (ws_grant) begin
            rf_we    = (ws_waddr_q != 5'd0);
            rf_waddr = ws_waddr_q;
            rf_wdata = ws_wdata_q;
        end else if (hold_grant) begin
            rf_we    = (hold_waddr_q != 5'd0);
            rf_waddr = hold_waddr_q;
            rf_wdata = hold_wdata_q;
        end
    end

    // Debug retire trace
    always_comb begin
        debug_wb_valid = ws_retire;
        debug_wb_pc    = ws_pc_q;
    end

    // Starvation counter next state: saturates so force_ll stays asserted
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!hold_valid_q || hold_grant) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != StarveMax) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    // Scoreboard next state: issue set is applied after drain clear so it wins
    always_comb begin
        busy_d = busy_q;
        if (hold_grant) begin
            busy_d[hold_waddr_q] = 1'b0;
        end
        if (ll_issue && (ll_issue_addr != 5'd0)) begin
            busy_d[ll_issue_addr] = 1'b1;
        end
    end

    // Scoreboard queries; a same-cycle drain is covered by the RF write bypass
    always_comb begin
        chk_busy1 = busy_q[chk_addr1] && (chk_addr1 != 5'd0)
                    && !(hold_grant && (hold_waddr_q == chk_addr1));
        chk_busy2 = busy_q[chk_addr2] && (chk_addr2 != 5'd0)
                    && !(hold_grant && (hold_waddr_q == chk_addr2));
    end

    // WB register: load on accept, otherwise drop the entry once it retires
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ws_valid_q <= 1'b0;
            ws_pc_q    <= 32'd0;
            ws_we_q    <= 1'b0;
            ws_waddr_q <= 5'd0;
            ws_wdata_q <= 32'd0;
        end else if (ms_fire) begin
            ws_valid_q <= 1'b1;
            ws_pc_q    <= ms_pc;
            ws_we_q    <= ms_we;
            ws_waddr_q <= ms_waddr;
            ws_wdata_q <= ms_wdata;
        end else if (ws_retire) begin
            ws_valid_q <= 1'b0;
        end
    end

    // Hold buffer: may refill in the same cycle it drains
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid_q <= 1'b0;
            hold_waddr_q <= 5'd0;
            hold_wdata_q <= 32'd0;
        end else if (ll_fire) begin
            hold_valid_q <= 1'b1;
            hold_waddr_q <= ll_waddr;
            hold_wdata_q <= ll_wdata;
        end else if (hold_grant) begin
            hold_valid_q <= 1'b0;
        end
    end

    // Starvation counter and scoreboard state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
            busy_q       <= 32'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            busy_q       <= busy_d;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ms_valid, ms_ready, ms_we;
    logic [31:0] ms_pc, ms_wdata;
    logic [4:0]  ms_waddr;
    logic        ll_valid, ll_ready;
    logic [4:0]  ll_waddr;
    logic [31:0] ll_wdata;
    logic        ll_issue;
    logic [4:0]  ll_issue_addr, chk_addr1, chk_addr2;
    logic        chk_busy1, chk_busy2;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] debug_wb_pc;
    logic        debug_wb_valid;

    int errors = 0;
    int checks = 0;

    wb_stage #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .ms_valid(ms_valid), .ms_ready(ms_ready), .ms_pc(ms_pc), .ms_we(ms_we),
        .ms_waddr(ms_waddr), .ms_wdata(ms_wdata),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_waddr(ll_waddr), .ll_wdata(ll_wdata),
        .ll_issue(ll_issue), .ll_issue_addr(ll_issue_addr),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
        .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .debug_wb_pc(debug_wb_pc), .debug_wb_valid(debug_wb_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ms_offer(input logic [31:0] pc, input logic we, input logic [4:0] a,
                            input logic [31:0] d);
        ms_valid = 1'b1; ms_pc = pc; ms_we = we; ms_waddr = a; ms_wdata = d;
    endtask

    task automatic ll_offer(input logic [4:0] a, input logic [31:0] d);
        ll_valid = 1'b1; ll_waddr = a; ll_wdata = d;
    endtask

    initial begin
        reset = 1'b1;
        ms_valid = 0; ms_pc = 0; ms_we = 0; ms_waddr = 0; ms_wdata = 0;
        ll_valid = 0; ll_waddr = 0; ll_wdata = 0;
        ll_issue = 0; ll_issue_addr = 0; chk_addr1 = 9; chk_addr2 = 0;

        // Reset state
        tick();
        check_eq("rst_ms_ready", 32'(ms_ready), 32'd1);
        check_eq("rst_ll_ready", 32'(ll_ready), 32'd1);
        check_eq("rst_rf_we", 32'(rf_we), 32'd0);
        check_eq("rst_dbg_valid", 32'(debug_wb_valid), 32'd0);
        check_eq("rst_busy1", 32'(chk_busy1), 32'd0);
        reset = 1'b0;
        tick();

        // Basic retire
        ms_offer(32'h1c00_0000, 1'b1, 5'd5, 32'hDEAD_BEEF);
        check_eq("basic_accept", 32'(ms_ready), 32'd1);
        tick();
        ms_valid = 0;
        check_eq("basic_rf_we", 32'(rf_we), 32'd1);
        check_eq("basic_waddr", 32'(rf_waddr), 32'd5);
        check_eq("basic_wdata", rf_wdata, 32'hDEAD_BEEF);
        check_eq("basic_dbg_valid", 32'(debug_wb_valid), 32'd1);
        check_eq("basic_dbg_pc", debug_wb_pc, 32'h1c00_0000);
        check_eq("basic_ms_ready", 32'(ms_ready), 32'd1);
        tick();
        check_eq("basic_idle_we", 32'(rf_we), 32'd0);
        check_eq("basic_idle_dbg", 32'(debug_wb_valid), 32'd0);

        // r0 suppression for both sources
        ms_offer(32'h100, 1'b1, 5'd0, 32'h1234);
        ll_offer(5'd0, 32'h55);
        tick();
        ms_valid = 0; ll_valid = 0;
        check_eq("r0_ms_we", 32'(rf_we), 32'd0);
        check_eq("r0_ms_dbg", 32'(debug_wb_valid), 32'd1);
        check_eq("r0_ll_wait", 32'(ll_ready), 32'd0);
        tick();
        check_eq("r0_ll_we", 32'(rf_we), 32'd0);
        check_eq("r0_ll_drain", 32'(ll_ready), 32'd1);
        check_eq("r0_ms_gone", 32'(debug_wb_valid), 32'd0);
        tick();

        // Contention: hold r7 loses 4 times, then is forced through
        ll_offer(5'd7, 32'h11);
        ms_offer(32'h400, 1'b1, 5'd11, 32'h101);
        tick();
        ll_valid = 0;
        for (int c = 1; c <= 4; c++) begin
            ms_offer(32'h400 + 32'(c), 1'b1, 5'(10 + c + 1), 32'h100 + 32'(c + 1));
            check_eq($sformatf("cont%0d_waddr", c), 32'(rf_waddr), 32'(10 + c));
            check_eq($sformatf("cont%0d_wdata", c), rf_wdata, 32'h100 + 32'(c));
            check_eq($sformatf("cont%0d_ms_ready", c), 32'(ms_ready), 32'd1);
            check_eq($sformatf("cont%0d_ll_ready", c), 32'(ll_ready), 32'd0);
            tick();
        end
        ms_offer(32'h405, 1'b1, 5'd16, 32'h106);
        check_eq("force_we", 32'(rf_we), 32'd1);
        check_eq("force_waddr", 32'(rf_waddr), 32'd7);
        check_eq("force_wdata", rf_wdata, 32'h11);
        check_eq("force_ms_ready", 32'(ms_ready), 32'd0);
        check_eq("force_dbg", 32'(debug_wb_valid), 32'd0);
        tick();
        check_eq("resume_waddr", 32'(rf_waddr), 32'd15);
        check_eq("resume_wdata", rf_wdata, 32'h105);
        check_eq("resume_ms_ready", 32'(ms_ready), 32'd1);
        tick();
        ms_valid = 0;
        check_eq("resume2_waddr", 32'(rf_waddr), 32'd16);
        tick();

        // Idle-slot drain: we=0 instruction lets the hold entry through
        ll_offer(5'd3, 32'h33);
        ms_offer(32'h200, 1'b0, 5'd4, 32'h44);
        tick();
        ms_valid = 0; ll_valid = 0;
        check_eq("idle_rf_we", 32'(rf_we), 32'd1);
        check_eq("idle_waddr", 32'(rf_waddr), 32'd3);
        check_eq("idle_wdata", rf_wdata, 32'h33);
        check_eq("idle_dbg_valid", 32'(debug_wb_valid), 32'd1);
        check_eq("idle_dbg_pc", debug_wb_pc, 32'h200);
        tick();

        // Scoreboard: set, query, clear on drain
        chk_addr1 = 9; chk_addr2 = 8;
        ll_issue = 1; ll_issue_addr = 9;
        check_eq("sb_not_yet", 32'(chk_busy1), 32'd0);
        tick();
        ll_issue = 0;
        check_eq("sb_busy9", 32'(chk_busy1), 32'd1);
        check_eq("sb_r8_free", 32'(chk_busy2), 32'd0);
        ll_offer(5'd9, 32'h99);
        check_eq("sb_busy9_still", 32'(chk_busy1), 32'd1);
        tick();
        ll_valid = 0;
        check_eq("sb_drain_bypass", 32'(chk_busy1), 32'd0);
        check_eq("sb_drain_waddr", 32'(rf_waddr), 32'd9);
        tick();
        check_eq("sb_cleared", 32'(chk_busy1), 32'd0);

        // Set and clear on the same register in the same cycle: set wins
        ll_issue = 1; ll_issue_addr = 9;
        tick();
        ll_issue = 0;
        ll_offer(5'd9, 32'h98);
        tick();
        ll_valid = 0;
        ll_issue = 1; ll_issue_addr = 9;
        check_eq("sb_coinc_bypass", 32'(chk_busy1), 32'd0);
        tick();
        ll_issue = 0;
        check_eq("sb_set_wins", 32'(chk_busy1), 32'd1);

        // r0 is never reported busy
        ll_issue = 1; ll_issue_addr = 0; chk_addr2 = 0;
        tick();
        ll_issue = 0;
        check_eq("sb_r0", 32'(chk_busy2), 32'd0);

        // Async reset with WB entry, hold entry and busy[9] present
        ms_offer(32'h300, 1'b1, 5'd12, 32'hC);
        ll_offer(5'd13, 32'hD);
        tick();
        ms_valid = 0; ll_valid = 0;
        check_eq("pre_rst_ll_ready", 32'(ll_ready), 32'd0);
        check_eq("pre_rst_busy9", 32'(chk_busy1), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_rf_we", 32'(rf_we), 32'd0);
        check_eq("arst_ms_ready", 32'(ms_ready), 32'd1);
        check_eq("arst_ll_ready", 32'(ll_ready), 32'd1);
        check_eq("arst_busy1", 32'(chk_busy1), 32'd0);
        check_eq("arst_dbg", 32'(debug_wb_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check_eq("post_rst_busy1", 32'(chk_busy1), 32'd0);
        check_eq("post_rst_rf_we", 32'(rf_we), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage directly upstream of the 32x32 register file. It holds the instruction retiring from the memory stage in a one-entry pipeline register and buffers one result from the long-latency unit (divider/multiplier). It arbitrates both sources onto the register file's single write port (`we`/`waddr`/`wdata`). It also keeps a pending-write scoreboard that decode uses to stall on registers still owed by the long-latency unit.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive cycles a buffered long-latency result may lose arbitration before it is forced through.
- `CNT_W`, default 3: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- `clk`: in, 1, sole clock; all state updates on the rising edge.
- `reset`: in, 1, asynchronous, active-high; clears all state.
- `ms_valid`: in, 1, the memory stage offers an instruction.
- `ms_ready`: out, 1, the stage accepts the offer this cycle.
- `ms_pc`: in, 32, PC of the offered instruction.
- `ms_we`: in, 1, the instruction writes a register.
- `ms_waddr`: in, 5, destination register.
- `ms_wdata`: in, 32, result.
- `ll_valid`: in, 1, the long-latency unit offers a result.
- `ll_ready`: out, 1, the hold buffer accepts the result this cycle.
- `ll_waddr`: in, 5, destination register of the long-latency result.
- `ll_wdata`: in, 32, long-latency result.
- `ll_issue`: in, 1, decode issues a long-latency op this cycle.
- `ll_issue_addr`: in, 5, destination register of the issued op.
- `chk_addr1`, `chk_addr2`: in, 5 each, decode source-register queries.
- `chk_busy1`, `chk_busy2`: out, 1 each, the queried register has a pending long-latency write.
- `rf_we`, `rf_waddr`, `rf_wdata`: out, 1/5/32, register-file write port.
- `debug_wb_pc`: out, 32, PC of the instruction retiring this cycle.
- `debug_wb_valid`: out, 1, an instruction retires this cycle.

## Operation
State:
- WB register: `ws_valid`, pc, we, waddr, wdata.
- Hold buffer: `hold_valid`, waddr, wdata.
- `starve_cnt`, CNT_W bits.
- `busy`, 32 bits.

Arbitration (combinational, per cycle):
- `force_ll = hold_valid & (starve_cnt == STARVE_LIMIT)`.
- `ws_grant = ws_valid & ws_we & !force_ll`.
- `hold_grant = hold_valid & !ws_grant`.
- `ws_retire = ws_valid & (!ws_we | ws_grant)`. A WB entry with we=0 retires without using the port.

Write port:
- When `ws_grant`: rf_* = WB entry.
- Else when `hold_grant`: rf_* = hold entry.
- Otherwise `rf_we = 0`.
- Writes to waddr 0 drive `rf_we = 0` but still count as granted and retire or drain normally.

Handshakes:
- `ms_ready = !ws_valid | ws_retire`. When `ms_valid & ms_ready`, the WB register loads the offer; otherwise, if `ws_retire`, `ws_valid` clears.
- `ll_ready = !hold_valid | hold_grant`. When `ll_valid & ll_ready`, the hold buffer loads; otherwise, if `hold_grant`, `hold_valid` clears.

Starvation counter:
- Cleared when `!hold_valid` or `hold_grant`.
- Otherwise increments, saturating at STARVE_LIMIT.

Scoreboard:
- `ll_issue` with a nonzero address sets `busy[ll_issue_addr]`.
- `hold_grant` clears `busy[hold_waddr]`.
- If set and clear hit the same address in the same cycle, set wins.
- `chk_busyN = busy[chk_addrN] & (chk_addrN != 0) & !(hold_grant & hold_waddr == chk_addrN)`. The register file's write bypass covers the same-cycle write.

Debug outputs:
- `debug_wb_valid = ws_retire`; `debug_wb_pc = ws_pc`.
- Long-latency writes are not reported on the debug outputs.

Ordering: the memory stage never issues a write to a register that is busy in the scoreboard. Decode enforces this via `chk_busy`; this block does not check it.

## Timing
- Reset (asynchronous, immediate):
  - `ws_valid = hold_valid = 0`, `starve_cnt = 0`, `busy = 0`, all data registers 0.
  - Resulting outputs: `ms_ready = ll_ready = 1`, `rf_we = 0`, `debug_wb_valid = 0`, `chk_busy* = 0`.
- Reset mid-operation drops any WB or hold entry and all busy bits.
- A memory-stage instruction accepted at edge N is written to the register file during cycle N+1 if it wins arbitration.
- A long-latency result accepted at edge N has its earliest write in cycle N+1.
- Back-to-back throughput is one write per cycle. The hold buffer may accept a new result in the same cycle it drains.
- A stalled WB entry holds its values stable. The memory stage must hold its offer until `ms_ready`.
- Forced-drain bound: a hold entry waits at most STARVE_LIMIT cycles before it is forced through.

## Test plan
- Basic retire: ms offer pc=0x1c000000, we=1, waddr=5, wdata=0xDEADBEEF. Expect next cycle `rf_we=1`, `rf_waddr=5`, `rf_wdata=0xDEADBEEF`, `debug_wb_valid=1`, `ms_ready=1`.
- r0 suppression: ms write to waddr=0 and ll result to waddr=0. Expect `rf_we=0` for both, both retire or drain, `debug_wb_valid=1` for the ms instruction.
- Contention: hold holds r7=0x11 while ms streams writes every cycle. Expect ms granted for 4 cycles, then `force_ll`: cycle 5 writes r7=0x11, `ms_ready=0` that cycle, and the stream resumes the following cycle.
- Idle-slot drain: ms issues a we=0 instruction while hold is valid. Expect the hold entry written the same cycle and the ms instruction retired.
- Scoreboard:
  - `ll_issue` r9: `chk_busy1=1` for r9 on later cycles.
  - In the cycle hold writes r9: `chk_busy1=0` and `busy[9]` clear afterwards.
  - `ll_issue` r9 coincident with drain of r9: `busy[9]` stays 1.
  - `ll_issue` r0: no bit set.
- Async reset: assert `reset` mid-cycle with a WB entry, a hold entry and `busy=0x00000200` present. Expect `rf_we=0`, `ms_ready=1`, `ll_ready=1`, `chk_busy*=0` before the next clock edge.
